// File: rtl/hack_pkg.sv
// hack_pkg: shared widths, reset constant and fetch-state encoding for the Hack core.
// Revision: 1.0
`default_nettype none

package hack_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;
  localparam int PC_RESET   = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// pc_reg: program-counter register with synchronous reset, branch load and increment.
// Revision: 1.0
`default_nettype none

module pc_reg
  import hack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Branch wins over increment; increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ADDR_W'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// pc_fetch: Hack PC and instruction-fetch stage (ROM req/ack, hold until retired).
// Optional macro HALT_DETECT_EN enables jump-to-self halt detection. Revision: 1.0
`default_nettype none

module pc_fetch
  import hack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              advance,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              rom_req_q, rom_req_d;
  logic              pc_load;
  logic              pc_inc;
  logic              retire;

  assign retire = advance && instr_valid_q;

`ifdef HALT_DETECT_EN
  logic halted_q, halted_d;
  logic halt_match;

  // "@END; 0;JMP" targets either the jump itself or the A-load just before it.
  assign halt_match = (jump_addr == pc) || (jump_addr == (pc - ADDR_W'(1)));
`endif

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    rom_req_d     = rom_req_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
`ifdef HALT_DETECT_EN
    halted_d      = halted_q;
`endif
    case (state_q)
      FETCH: begin
        // After reset the request is raised one cycle later; acks are ignored until then.
        if (!rom_req_q) begin
          rom_req_d = 1'b1;
        end else if (rom_ack) begin
          instr_d       = rom_data;
          instr_valid_d = 1'b1;
          rom_req_d     = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          instr_valid_d = 1'b0;
          rom_req_d     = 1'b1;
          state_d       = FETCH;
          if (load) begin
            pc_load = 1'b1;
`ifdef HALT_DETECT_EN
            if (halt_match) begin
              rom_req_d = 1'b0;
              halted_d  = 1'b1;
              state_d   = HALT;
            end
`endif
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
`ifdef HALT_DETECT_EN
      HALT: begin
        rom_req_d     = 1'b0;
        instr_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d       = FETCH;
        instr_valid_d = 1'b0;
        rom_req_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      rom_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      rom_req_q     <= rom_req_d;
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jump_addr),
    .pc       (pc)
  );

  assign rom_req     = rom_req_q;
  assign rom_addr    = pc;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch with a wait-state ROM model.
// Revision: 1.0
`default_nettype none

module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [14:0] jump_addr;
  logic        advance;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic [14:0] pc;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        force_ack = 1'b0;
  logic        model_ack;

  always #5 clk = ~clk;

  // ROM content: word at addr a is 0x1234 + a; ack after wait_cfg stalled cycles.
  assign model_ack = rom_req && (wait_cnt == wait_cfg);
  assign rom_ack   = model_ack || force_ack;
  assign rom_data  = 16'h1234 + {1'b0, rom_addr};

  always @(posedge clk) begin
    if (!rom_req || model_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  pc_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .jump_addr   (jump_addr),
    .advance     (advance),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_advance(input logic ld, input logic [14:0] tgt);
    advance   = 1'b1;
    load      = ld;
    jump_addr = tgt;
    step();
    advance = 1'b0;
    load    = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; jump_addr = '0; advance = 1'b0;
    step();
    step();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(rom_req), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;

    // First fetch, zero-wait ROM
    step();
    chk("f0_req", 32'(rom_req), 32'h1);
    chk("f0_addr", 32'(rom_addr), 32'h0);
    step();
    chk("f0_instr", 32'(instr), 32'h1234);
    chk("f0_valid", 32'(instr_valid), 32'h1);
    chk("f0_pc", 32'(pc), 32'h0);

    // Sequential run
    for (int i = 1; i <= 3; i++) begin
      advance = 1'b1;
      step();
      advance = 1'b0;
      chk("seq_valid_drop", 32'(instr_valid), 32'h0);
      chk("seq_req", 32'(rom_req), 32'h1);
      chk("seq_addr", 32'(rom_addr), 32'(i));
      step();
      chk("seq_valid", 32'(instr_valid), 32'h1);
      chk("seq_instr", 32'(instr), 32'h1234 + 32'(i));
    end

    // Branch from pc=5
    do_advance(1'b0, 15'h0);
    do_advance(1'b0, 15'h0);
    chk("br_pc5", 32'(pc), 32'h5);
    advance = 1'b1; load = 1'b1; jump_addr = 15'h0100;
    step();
    chk("br_addr", 32'(rom_addr), 32'h0100);
    chk("br_valid", 32'(instr_valid), 32'h0);
    // advance during the fetch cycle must be ignored
    jump_addr = 15'h0200;
    step();
    advance = 1'b0; load = 1'b0;
    chk("br_ign_pc", 32'(pc), 32'h0100);
    chk("br_instr", 32'(instr), 32'h1334);
    chk("br_valid2", 32'(instr_valid), 32'h1);

    // Wrap with 3 ROM wait states
    do_advance(1'b1, 15'h7FFF);
    chk("wr_pc_top", 32'(pc), 32'h7FFF);
    wait_cfg = 3;
    advance = 1'b1;
    step();
    advance = 1'b0;
    chk("wr_pc0", 32'(pc), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_req", 32'(rom_req), 32'h1);
      chk("ws_addr", 32'(rom_addr), 32'h0);
      chk("ws_valid", 32'(instr_valid), 32'h0);
    end
    step();
    chk("ws_valid_rise", 32'(instr_valid), 32'h1);
    chk("ws_instr", 32'(instr), 32'h1234);

    // Reset during a wait state with a coincident ack
    advance = 1'b1;
    step();
    advance = 1'b0;
    chk("rm_pc1", 32'(pc), 32'h1);
    step();
    reset = 1'b1; force_ack = 1'b1;
    step();
    reset = 1'b0; force_ack = 1'b0;
    chk("rm_pc", 32'(pc), 32'h0);
    chk("rm_valid", 32'(instr_valid), 32'h0);
    chk("rm_instr", 32'(instr), 32'h0);
    wait_cfg = 0;
    step();
    chk("rm_req", 32'(rom_req), 32'h1);
    chk("rm_addr", 32'(rom_addr), 32'h0);
    step();
    chk("rm_refetch", 32'(instr), 32'h1234);

    // Jump to pc-1 (halt idiom)
    do_advance(1'b1, 15'h0011);
    chk("h_pc", 32'(pc), 32'h0011);
    advance = 1'b1; load = 1'b1; jump_addr = 15'h0010;
    step();
    advance = 1'b0; load = 1'b0;
    chk("h_pc_upd", 32'(pc), 32'h0010);
`ifdef HALT_DETECT_EN
    chk("h_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 12; i++) begin
      advance = i[0];
      step();
      chk("h_req", 32'(rom_req), 32'h0);
      chk("h_valid", 32'(instr_valid), 32'h0);
    end
    advance = 1'b0;
    chk("h_pc_hold", 32'(pc), 32'h0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("h_rst", 32'(halted), 32'h0);
`else
    chk("nh_halted", 32'(halted), 32'h0);
    chk("nh_req", 32'(rom_req), 32'h1);
    chk("nh_addr", 32'(rom_addr), 32'h0010);
    step();
    chk("nh_instr", 32'(instr), 32'h1244);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
